// File: rtl/alu_seq.sv
// Registered sequential ALU: valid/ready in and out, iterative shifts with carry in/out.
// Optional ALU_SEQ_MUL_EN adds opcode 1001, an iterative shift-add unsigned multiply.
module alu_seq #(
    parameter int unsigned W     = 8,
    parameter int unsigned CMD_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [CMD_W-1:0] alu_cmd,
    input  logic [W-1:0]     inA,
    input  logic [W-1:0]     inB,
    input  logic             sc_i,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     rslt,
    output logic             sc_o,
    output logic             pari,
    output logic             zero
);

    localparam int unsigned CNT_W = $clog2(W + 1);
    localparam int unsigned CMP_W = W + 32;

    localparam logic [3:0] OP_XOR = 4'h1;
    localparam logic [3:0] OP_NE  = 4'h2;
    localparam logic [3:0] OP_ADD = 4'h3;
    localparam logic [3:0] OP_SHL = 4'h4;
    localparam logic [3:0] OP_SHR = 4'h5;
    localparam logic [3:0] OP_PB  = 4'h6;
    localparam logic [3:0] OP_PA  = 4'h7;
    localparam logic [3:0] OP_PAR = 4'h8;
`ifdef ALU_SEQ_MUL_EN
    localparam logic [3:0] OP_MUL = 4'h9;
`endif

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_HOLD} state_e;
    typedef enum logic [1:0] {M_SHL, M_SHR, M_MUL} mode_e;

    state_e           state_q, state_d;
    mode_e            mode_q, mode_d;
    logic [W-1:0]     rslt_q, rslt_d;
    logic             sc_q, sc_d;
    logic             pari_q, pari_d;
    logic             zero_q, zero_d;
    logic             vld_q, vld_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fill_q, fill_d;
`ifdef ALU_SEQ_MUL_EN
    logic [W-1:0]     mcand_q, mcand_d;
    logic [W-1:0]     hi_q, hi_d;
    logic [W:0]       mul_sum;
`endif
    logic [3:0]       cmd;
    logic             accept;
    logic             load;

    assign in_ready  = (state_q == S_IDLE) | ((state_q == S_HOLD) & out_ready);
    assign out_valid = vld_q;
    assign rslt      = rslt_q;
    assign sc_o      = sc_q;
    assign pari      = pari_q;
    assign zero      = zero_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            mode_q  <= M_SHL;
            rslt_q  <= '0;
            sc_q    <= 1'b0;
            pari_q  <= 1'b0;
            zero_q  <= 1'b0;
            vld_q   <= 1'b0;
            cnt_q   <= '0;
            fill_q  <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            mcand_q <= '0;
            hi_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            rslt_q  <= rslt_d;
            sc_q    <= sc_d;
            pari_q  <= pari_d;
            zero_q  <= zero_d;
            vld_q   <= vld_d;
            cnt_q   <= cnt_d;
            fill_q  <= fill_d;
`ifdef ALU_SEQ_MUL_EN
            mcand_q <= mcand_d;
            hi_q    <= hi_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        rslt_d  = rslt_q;
        sc_d    = sc_q;
        pari_d  = pari_q;
        zero_d  = zero_q;
        cnt_d   = cnt_q;
        fill_d  = fill_q;
`ifdef ALU_SEQ_MUL_EN
        mcand_d = mcand_q;
        hi_d    = hi_q;
        mul_sum = (W+1)'(hi_q) + (rslt_q[0] ? (W+1)'(mcand_q) : (W+1)'(0));
`endif
        cmd    = 4'(alu_cmd);
        accept = in_valid & in_ready;
        load   = 1'b0;

        // One iteration step per BUSY cycle; the working value lives in rslt_q.
        case (state_q)
            S_BUSY: begin
                load  = 1'b1;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_HOLD;
                end
                case (mode_q)
                    M_SHL: begin
                        sc_d   = rslt_q[W-1];
                        rslt_d = {rslt_q[W-2:0], fill_q};
                    end
                    M_SHR: begin
                        sc_d   = rslt_q[0];
                        rslt_d = {fill_q, rslt_q[W-1:1]};
                    end
`ifdef ALU_SEQ_MUL_EN
                    M_MUL: begin
                        {hi_d, rslt_d} = {mul_sum, rslt_q[W-1:1]};
                        sc_d           = |hi_d;
                    end
`endif
                    default: ;
                endcase
            end
            S_HOLD: begin
                if (out_ready && !in_valid) begin
                    state_d = S_IDLE;
                end
            end
            default: ;
        endcase

        if (accept) begin
            load    = 1'b1;
            state_d = S_HOLD;
            rslt_d  = '0;
            sc_d    = 1'b0;
            fill_d  = sc_i;
            case (cmd)
                OP_XOR: rslt_d = inA ^ inB;
                OP_NE:  rslt_d = W'(inA != inB);
                OP_ADD: {sc_d, rslt_d} = (W+1)'(inA) + (W+1)'(inB) + (W+1)'(sc_i);
                OP_SHL, OP_SHR: begin
                    rslt_d = inB;
                    mode_d = (cmd == OP_SHL) ? M_SHL : M_SHR;
                    // Over-range amounts saturate at W steps.
                    if (CMP_W'(inA) >= CMP_W'(W)) begin
                        cnt_d = CNT_W'(W);
                    end else begin
                        cnt_d = CNT_W'(inA);
                    end
                    if (inA != '0) begin
                        state_d = S_BUSY;
                    end
                end
                OP_PB:  rslt_d = inB;
                OP_PA:  rslt_d = inA;
                OP_PAR: rslt_d = W'(^inB);
`ifdef ALU_SEQ_MUL_EN
                OP_MUL: begin
                    rslt_d  = inA;
                    hi_d    = '0;
                    mcand_d = inB;
                    cnt_d   = CNT_W'(W);
                    mode_d  = M_MUL;
                    state_d = S_BUSY;
                end
`endif
                default: ;
            endcase
        end

        if (load) begin
            pari_d = ^rslt_d;
            zero_d = (rslt_d == '0);
        end
        vld_d = (state_d == S_HOLD);
    end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq (W=8): directed literal cases plus randomized traffic against a
// transaction-level reference model; honours ALU_SEQ_MUL_EN the same way as the design.
module tb_alu_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] alu_cmd = 4'h0;
    logic [7:0] inA = 8'h00;
    logic [7:0] inB = 8'h00;
    logic       sc_i = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] rslt;
    logic       sc_o;
    logic       pari;
    logic       zero;

    int tests = 0;
    int fails = 0;

    alu_seq #(.W(8), .CMD_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .alu_cmd(alu_cmd), .inA(inA), .inB(inB), .sc_i(sc_i),
        .out_valid(out_valid), .out_ready(out_ready),
        .rslt(rslt), .sc_o(sc_o), .pari(pari), .zero(zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Expected result, carry and latency of one operation, from the arithmetic meaning of each opcode.
    function automatic void calc(input logic [3:0] c, input logic [7:0] a, input logic [7:0] b,
                                 input logic s, output logic [7:0] r, output logic so, output int lat);
        logic [15:0] t;
        int n;
        r   = 8'h00;
        so  = 1'b0;
        lat = 1;
        n   = (a >= 8'd8) ? 8 : int'(a);
        case (c)
            4'h1: r = a ^ b;
            4'h2: r = 8'(a != b);
            4'h3: begin t = 16'(a) + 16'(b) + 16'(s); r = t[7:0]; so = t[8]; end
            4'h4: begin
                if (n > 0) begin
                    t   = 16'(b) << n;
                    r   = t[7:0] | (s ? 8'((1 << n) - 1) : 8'h00);
                    so  = t[8];
                    lat = n + 1;
                end else r = b;
            end
            4'h5: begin
                if (n > 0) begin
                    t   = {b, 8'h00} >> n;
                    r   = t[15:8] | (s ? 8'(8'hFF << (8 - n)) : 8'h00);
                    so  = t[7];
                    lat = n + 1;
                end else r = b;
            end
            4'h6: r = b;
            4'h7: r = a;
            4'h8: r = 8'(^b);
`ifdef ALU_SEQ_MUL_EN
            4'h9: begin t = 16'(a) * 16'(b); r = t[7:0]; so = |t[15:8]; lat = 9; end
`endif
            default: ;
        endcase
    endfunction

    // Reference model: pending op counts down, then holds until consumed.
    logic       m_valid = 1'b0;
    int         m_busy = 0;
    logic [7:0] m_r = 8'h00, p_r = 8'h00;
    logic       m_s = 1'b0, p_s = 1'b0;
    logic       acc;
    logic [7:0] c_r;
    logic       c_s;
    int         c_l;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_busy  <= 0;
        end else begin
            acc = in_valid && (m_busy == 0) && (!m_valid || out_ready);
            calc(alu_cmd, inA, inB, sc_i, c_r, c_s, c_l);
            if (m_busy > 0) begin
                m_busy <= m_busy - 1;
                if (m_busy == 1) begin
                    m_valid <= 1'b1;
                    m_r     <= p_r;
                    m_s     <= p_s;
                end
            end else if (acc) begin
                if (c_l == 1) begin
                    m_valid <= 1'b1;
                    m_r     <= c_r;
                    m_s     <= c_s;
                end else begin
                    m_valid <= 1'b0;
                    m_busy  <= c_l - 1;
                    p_r     <= c_r;
                    p_s     <= c_s;
                end
            end else if (m_valid && out_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("out_valid", 16'(out_valid), 16'(m_valid));
            chk("in_ready", 16'(in_ready), 16'((m_busy == 0) && (!m_valid || out_ready)));
            if (m_valid) begin
                chk("rslt", 16'(rslt), 16'(m_r));
                chk("sc_o", 16'(sc_o), 16'(m_s));
                chk("pari", 16'(pari), 16'(^m_r));
                chk("zero", 16'(zero), 16'(m_r == 8'h00));
            end
        end
    end

    task automatic run_op(input string nm, input logic [3:0] c, input logic [7:0] a, input logic [7:0] b,
                          input logic s, input logic [7:0] er, input logic es, input logic ep,
                          input logic ez, input int el);
        int lat;
        @(posedge clk); #1;
        alu_cmd = c; inA = a; inB = b; sc_i = s; in_valid = 1'b1; out_ready = 1'b1;
        chk({nm, "_rdy"}, 16'(in_ready), 16'd1);
        @(posedge clk); #1;
        in_valid = 1'b0; inA = ~a; inB = ~b; sc_i = ~s;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({nm, "_lat"}, 16'(lat), 16'(el));
        chk({nm, "_rslt"}, 16'(rslt), 16'(er));
        chk({nm, "_sc"}, 16'(sc_o), 16'(es));
        chk({nm, "_pari"}, 16'(pari), 16'(ep));
        chk({nm, "_zero"}, 16'(zero), 16'(ez));
    endtask

    initial begin
        #12;
        chk("rst_valid", 16'(out_valid), 16'd0);
        chk("rst_rslt", 16'(rslt), 16'd0);
        chk("rst_zero", 16'(zero), 16'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1 chk("rst_ready", 16'(in_ready), 16'd1);

        run_op("add",   4'h3, 8'hF0, 8'h20, 1'b1, 8'h11, 1'b1, 1'b0, 1'b0, 1);
        run_op("xor",   4'h1, 8'h5A, 8'h5A, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1);
        run_op("shl3",  4'h4, 8'd3,  8'hA1, 1'b0, 8'h08, 1'b1, 1'b1, 1'b0, 4);
        run_op("shr9",  4'h5, 8'd9,  8'h81, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 9);
        run_op("shl0",  4'h4, 8'd0,  8'h33, 1'b1, 8'h33, 1'b0, 1'b0, 1'b0, 1);
        run_op("ne",    4'h2, 8'h03, 8'h04, 1'b0, 8'h01, 1'b0, 1'b1, 1'b0, 1);
        run_op("par",   4'h8, 8'h00, 8'h07, 1'b0, 8'h01, 1'b0, 1'b1, 1'b0, 1);
        run_op("ill",   4'h0, 8'hFF, 8'hFF, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1);
`ifdef ALU_SEQ_MUL_EN
        run_op("mul",   4'h9, 8'h10, 8'h11, 1'b0, 8'h10, 1'b1, 1'b1, 1'b0, 9);
`else
        run_op("mul",   4'h9, 8'h10, 8'h11, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1);
`endif

        // Backpressure, then back-to-back issue while the held result is taken.
        @(posedge clk); #1;
        out_ready = 1'b0; alu_cmd = 4'h6; inB = 8'hA5; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 16'(out_valid), 16'd1);
            chk("bp_rslt", 16'(rslt), 16'hA5);
            chk("bp_ready", 16'(in_ready), 16'd0);
            @(posedge clk); #1;
        end
        alu_cmd = 4'h7; inA = 8'h3C; in_valid = 1'b1; out_ready = 1'b1;
        #1 chk("b2b_ready", 16'(in_ready), 16'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("b2b_valid", 16'(out_valid), 16'd1);
        chk("b2b_rslt", 16'(rslt), 16'h3C);

        // Reset in the middle of a long shift.
        @(posedge clk); #1;
        alu_cmd = 4'h5; inA = 8'd8; inB = 8'hFF; sc_i = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("mrst_valid", 16'(out_valid), 16'd0);
        chk("mrst_rslt", 16'(rslt), 16'd0);
        chk("mrst_sc", 16'(sc_o), 16'd0);
        chk("mrst_pari", 16'(pari), 16'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1 chk("mrst_ready", 16'(in_ready), 16'd1);
        repeat (12) @(posedge clk);
        #1 chk("mrst_novalid", 16'(out_valid), 16'd0);

        // Randomized traffic with random backpressure; the model checks every cycle.
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            in_valid  = ($urandom_range(0, 9) < 6);
            out_ready = ($urandom_range(0, 9) < 7);
            alu_cmd   = 4'($urandom_range(0, 15));
            inA       = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 10));
            inB       = 8'($urandom_range(0, 255));
            sc_i      = 1'($urandom_range(0, 1));
        end
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
